// File: rtl/feature_weight_bank.sv
// Double-buffered convolution weight store. Filters are loaded word by word
// into the shadow bank while the active bank drives weights_out; once every
// shadow filter is valid, a swap request exchanges the two banks.
module feature_weight_bank #(
    parameter int KERNEL_SIZE  = 3,
    parameter int NUM_FEATURES = 10,
    parameter int NUM_CHANNELS = 1,
    parameter int WEIGHT_WIDTH = 8,
    localparam int WPF     = NUM_CHANNELS * KERNEL_SIZE * KERNEL_SIZE,
    localparam int FW      = ($clog2(NUM_FEATURES) > 1) ? $clog2(NUM_FEATURES) : 1,
    localparam int TOTAL_W = NUM_FEATURES * WPF * WEIGHT_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load_start,
    input  logic [FW-1:0]           load_feature,
    input  logic                    abort,
    input  logic                    w_valid,
    input  logic [WEIGHT_WIDTH-1:0] w_data,
    output logic                    w_ready,
    output logic                    load_busy,
    output logic                    load_done,
    output logic                    load_err,
    input  logic                    swap_req,
    output logic                    swap_ack,
    output logic                    shadow_full,
    output logic                    active_bank,
    output logic [TOTAL_W-1:0]      weights_out
);

    localparam int CW = ($clog2(WPF) > 1) ? $clog2(WPF) : 1;
    localparam logic [CW-1:0] LAST_WORD = CW'(WPF - 1);
    // One extra bit so an index equal to 2**FW still compares correctly.
    localparam logic [FW:0] NF_LIMIT = (FW + 1)'(NUM_FEATURES);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [FW-1:0]          feat_q, feat_d;
    logic [NUM_FEATURES-1:0] valid_q, valid_d;
    logic                   active_bank_q, active_bank_d;
    logic                   load_err_q, load_err_d;
    logic                   swap_ack_q, swap_ack_d;
    logic [TOTAL_W-1:0]     bank_q [2];
    logic [TOTAL_W-1:0]     bank_d [2];
    logic [31:0]            widx_s;
    logic                   full_s;

    assign full_s      = &valid_q;
    assign w_ready     = (state_q == ST_LOAD);
    assign load_busy   = (state_q != ST_IDLE);
    assign load_done   = (state_q == ST_DONE);
    assign load_err    = load_err_q;
    assign swap_ack    = swap_ack_q;
    assign shadow_full = full_s;
    assign active_bank = active_bank_q;
    assign weights_out = bank_q[active_bank_q];

    // Next-state logic for the loader, shadow writes, valid bits and bank swap.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        feat_d        = feat_q;
        valid_d       = valid_q;
        active_bank_d = active_bank_q;
        load_err_d    = 1'b0;
        swap_ack_d    = 1'b0;
        bank_d        = bank_q;
        widx_s        = 32'(feat_q) * 32'(WPF) + 32'(cnt_q);
        case (state_q)
            ST_IDLE: begin
                if (load_start) begin
                    // A load request always wins over a pending swap.
                    if ({1'b0, load_feature} >= NF_LIMIT) begin
                        load_err_d = 1'b1;
                    end else begin
                        state_d               = ST_LOAD;
                        cnt_d                 = '0;
                        feat_d                = load_feature;
                        valid_d[load_feature] = 1'b0;
                    end
                end else if (swap_req && full_s) begin
                    active_bank_d = ~active_bank_q;
                    valid_d       = '0;
                    swap_ack_d    = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (abort) begin
                    // Words already written stay in the shadow bank but the
                    // feature is left invalid.
                    state_d = ST_IDLE;
                end else if (w_valid) begin
                    bank_d[~active_bank_q][widx_s*WEIGHT_WIDTH +: WEIGHT_WIDTH] = w_data;
                    if (cnt_q == LAST_WORD) begin
                        state_d = ST_DONE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_DONE: begin
                valid_d[feat_q] = 1'b1;
                state_d         = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and storage registers with asynchronous active-low clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            feat_q        <= '0;
            valid_q       <= '0;
            active_bank_q <= 1'b0;
            load_err_q    <= 1'b0;
            swap_ack_q    <= 1'b0;
            bank_q[0]     <= '0;
            bank_q[1]     <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            feat_q        <= feat_d;
            valid_q       <= valid_d;
            active_bank_q <= active_bank_d;
            load_err_q    <= load_err_d;
            swap_ack_q    <= swap_ack_d;
            bank_q[0]     <= bank_d[0];
            bank_q[1]     <= bank_d[1];
        end
    end

endmodule

// File: tb/tb_feature_weight_bank.sv
// Directed bench for feature_weight_bank (K=3, 4 features, 1 channel, 8-bit).
// A second small instance with 5 features covers the out-of-range index path,
// which a 2-bit index cannot reach on the 4-feature instance.
module tb_feature_weight_bank;

    localparam int K   = 3;
    localparam int NF  = 4;
    localparam int NC  = 1;
    localparam int WW  = 8;
    localparam int WPF = NC * K * K;
    localparam int TW  = NF * WPF * WW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          load_start = 1'b0;
    logic [1:0]    load_feature = 2'd0;
    logic          abort = 1'b0;
    logic          w_valid = 1'b0;
    logic [7:0]    w_data = 8'd0;
    logic          w_ready, load_busy, load_done, load_err;
    logic          swap_req = 1'b0;
    logic          swap_ack, shadow_full, active_bank;
    logic [TW-1:0] weights_out;

    logic          e_load_start = 1'b0;
    logic [2:0]    e_load_feature = 3'd0;
    logic          e_w_ready, e_load_busy, e_load_done, e_load_err;
    logic          e_swap_ack, e_shadow_full, e_active_bank;
    logic [39:0]   e_weights_out;

    int passed = 0;
    int total  = 0;

    feature_weight_bank #(
        .KERNEL_SIZE(K), .NUM_FEATURES(NF), .NUM_CHANNELS(NC), .WEIGHT_WIDTH(WW)
    ) dut (
        .clk(clk), .rst(rst), .load_start(load_start), .load_feature(load_feature),
        .abort(abort), .w_valid(w_valid), .w_data(w_data), .w_ready(w_ready),
        .load_busy(load_busy), .load_done(load_done), .load_err(load_err),
        .swap_req(swap_req), .swap_ack(swap_ack), .shadow_full(shadow_full),
        .active_bank(active_bank), .weights_out(weights_out)
    );

    feature_weight_bank #(
        .KERNEL_SIZE(1), .NUM_FEATURES(5), .NUM_CHANNELS(1), .WEIGHT_WIDTH(8)
    ) dut_err (
        .clk(clk), .rst(rst), .load_start(e_load_start), .load_feature(e_load_feature),
        .abort(1'b0), .w_valid(1'b0), .w_data(8'd0), .w_ready(e_w_ready),
        .load_busy(e_load_busy), .load_done(e_load_done), .load_err(e_load_err),
        .swap_req(1'b0), .swap_ack(e_swap_ack), .shadow_full(e_shadow_full),
        .active_bank(e_active_bank), .weights_out(e_weights_out)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [TW-1:0] obs, input logic [TW-1:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [7:0] wsel(input int f, input int i);
        return weights_out[(f*WPF+i)*WW +: WW];
    endfunction

    // Full load of one feature with continuous w_valid, words base+i.
    task automatic do_load(input logic [1:0] f, input logic [7:0] base,
                           output int ready_cycles, output int acks, output bit done_ok);
        load_start   = 1'b1;
        load_feature = f;
        step();
        load_start   = 1'b0;
        ready_cycles = 0;
        acks         = 0;
        for (int i = 0; i < WPF; i++) begin
            w_valid = 1'b1;
            w_data  = base + 8'(i);
            if (w_ready) ready_cycles++;
            if (swap_ack) acks++;
            step();
        end
        w_valid = 1'b0;
        w_data  = 8'd0;
        done_ok = load_done && !w_ready && load_busy;
        if (swap_ack) acks++;
        step();
        done_ok = done_ok && !load_done && !load_busy;
    endtask

    initial begin
        int  rc;
        int  ak;
        bit  ok;

        // Reset state
        #1 rst = 1'b0;
        #1;
        chk("rst_w_ready",     TW'(w_ready),     '0);
        chk("rst_load_busy",   TW'(load_busy),   '0);
        chk("rst_load_done",   TW'(load_done),   '0);
        chk("rst_load_err",    TW'(load_err),    '0);
        chk("rst_swap_ack",    TW'(swap_ack),    '0);
        chk("rst_shadow_full", TW'(shadow_full), '0);
        chk("rst_active_bank", TW'(active_bank), '0);
        chk("rst_weights",     weights_out,      '0);
        step();
        @(negedge clk) rst = 1'b1;
        step();

        // Feature 2 with words 1..9
        do_load(2'd2, 8'd1, rc, ak, ok);
        chk("l2_ready_cycles", TW'(rc), TW'(9));
        chk("l2_done_pulse",   TW'(ok), TW'(1));
        chk("l2_weights_zero", weights_out, '0);
        chk("l2_not_full",     TW'(shadow_full), '0);

        // Features 0,1,3 then reload 2 with f*16+i, then swap
        do_load(2'd0, 8'h00, rc, ak, ok);
        do_load(2'd1, 8'h10, rc, ak, ok);
        do_load(2'd3, 8'h30, rc, ak, ok);
        chk("full_before_reload", TW'(shadow_full), TW'(1));
        load_start   = 1'b1;
        load_feature = 2'd2;
        step();
        load_start   = 1'b0;
        chk("reload_clears_valid", TW'(shadow_full), '0);
        for (int i = 0; i < WPF; i++) begin
            w_valid = 1'b1;
            w_data  = 8'h20 + 8'(i);
            step();
        end
        w_valid = 1'b0;
        chk("reload_done", TW'(load_done), TW'(1));
        step();
        chk("full_after_reload", TW'(shadow_full), TW'(1));
        chk("weights_before_swap", weights_out, '0);
        swap_req = 1'b1;
        step();
        swap_req = 1'b0;
        chk("swap_ack",      TW'(swap_ack),    TW'(1));
        chk("swap_bank",     TW'(active_bank), TW'(1));
        chk("swap_not_full", TW'(shadow_full), '0);
        chk("w_f3_i8",       TW'(wsel(3, 8)),  TW'(8'h38));
        chk("w_f2_i0",       TW'(wsel(2, 0)),  TW'(8'h20));
        chk("w_f1_i4",       TW'(wsel(1, 4)),  TW'(8'h14));
        chk("w_f0_i7",       TW'(wsel(0, 7)),  TW'(8'h07));
        step();
        chk("swap_ack_one_cycle", TW'(swap_ack), '0);

        // Out-of-range index on the 5-feature instance
        e_load_start   = 1'b1;
        e_load_feature = 3'd5;
        step();
        e_load_start   = 1'b0;
        chk("err_pulse", TW'(e_load_err),  TW'(1));
        chk("err_busy",  TW'(e_load_busy), '0);
        step();
        chk("err_one_cycle", TW'(e_load_err),  '0);
        chk("err_busy_idle", TW'(e_load_busy), '0);

        // Feature 1 with gaps, abort after the fourth word
        load_start   = 1'b1;
        load_feature = 2'd1;
        step();
        load_start   = 1'b0;
        w_valid = 1'b1; w_data = 8'hA0; step();
        w_valid = 1'b0; w_data = 8'hFF; step();
        w_valid = 1'b1; w_data = 8'hA1; step();
        w_valid = 1'b1; w_data = 8'hA2; step();
        w_valid = 1'b0;                 step();
        w_valid = 1'b1; w_data = 8'hA3; step();
        abort   = 1'b1; w_data = 8'hEE;
        chk("abort_still_busy", TW'(load_busy), TW'(1));
        step();
        abort   = 1'b0;
        w_valid = 1'b0;
        chk("abort_idle",    TW'(load_busy), '0);
        chk("abort_no_done", TW'(load_done), '0);
        step();
        chk("abort_no_done_late", TW'(load_done),   '0);
        chk("abort_not_full",     TW'(shadow_full), '0);
        swap_req = 1'b1;
        step();
        swap_req = 1'b0;
        chk("abort_no_ack",      TW'(swap_ack),    '0);
        chk("abort_bank_kept",   TW'(active_bank), TW'(1));
        chk("abort_active_kept", TW'(wsel(1, 0)),  TW'(8'h10));

        // Swap requested while the last feature is loading
        do_load(2'd0, 8'h80, rc, ak, ok);
        do_load(2'd1, 8'h90, rc, ak, ok);
        do_load(2'd2, 8'hA0, rc, ak, ok);
        swap_req = 1'b1;
        load_start   = 1'b1;
        load_feature = 2'd3;
        step();
        load_start   = 1'b0;
        ak = 0;
        for (int i = 0; i < WPF; i++) begin
            w_valid = 1'b1;
            w_data  = 8'hB0 + 8'(i);
            if (swap_ack) ak++;
            step();
        end
        w_valid = 1'b0;
        chk("held_swap_done", TW'(load_done), TW'(1));
        if (swap_ack) ak++;
        step();
        if (swap_ack) ak++;
        chk("held_swap_no_early_ack", TW'(ak), '0);
        chk("held_swap_full",         TW'(shadow_full), TW'(1));
        step();
        swap_req = 1'b0;
        chk("held_swap_ack",  TW'(swap_ack),    TW'(1));
        chk("held_swap_bank", TW'(active_bank), '0);
        chk("held_w_f3_i8",   TW'(wsel(3, 8)),  TW'(8'hB8));
        chk("held_w_f0_i0",   TW'(wsel(0, 0)),  TW'(8'h80));
        chk("held_w_f1_i3",   TW'(wsel(1, 3)),  TW'(8'h93));
        step();

        // Reset in the middle of a load
        load_start   = 1'b1;
        load_feature = 2'd0;
        step();
        load_start   = 1'b0;
        for (int i = 0; i < 4; i++) begin
            w_valid = 1'b1;
            w_data  = 8'h40 + 8'(i);
            step();
        end
        w_data = 8'h44;
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_ready",   TW'(w_ready),     '0);
        chk("mid_rst_busy",    TW'(load_busy),   '0);
        chk("mid_rst_bank",    TW'(active_bank), '0);
        chk("mid_rst_weights", weights_out,      '0);
        w_valid = 1'b0;
        step();
        @(negedge clk) rst = 1'b1;
        step();
        chk("post_rst_no_done", TW'(load_done), '0);
        step();
        chk("post_rst_idle", TW'(load_busy), '0);
        do_load(2'd0, 8'h50, rc, ak, ok);
        chk("post_rst_ready_cycles", TW'(rc), TW'(9));
        chk("post_rst_load_done",    TW'(ok), TW'(1));
        chk("post_rst_weights",      weights_out, '0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
